// File: rtl/wide_add_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : wide_add_pkg
// Brief   : Shared slice width and FSM state encoding for the wide add
//           sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package wide_add_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/wide_add_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : wide_add_sequencer_if
// Brief   : Operand request / result handshake bundle of the wide add
//           sequencer. in_sub exists only when WIDE_ADD_SUB_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
interface wide_add_sequencer_if #(
    parameter int WORDS = 4
);
    import wide_add_pkg::*;

    localparam int c_W = SLICE_W * WORDS;

    logic           in_valid;
    logic           in_ready;
    logic [c_W-1:0] in_a;
    logic [c_W-1:0] in_b;
    logic           in_cin;
`ifdef WIDE_ADD_SUB_EN
    logic           in_sub;
`endif
    logic           out_valid;
    logic           out_ready;
    logic [c_W-1:0] out_sum;
    logic           out_cout;

    modport master (
        output in_valid, in_a, in_b, in_cin,
`ifdef WIDE_ADD_SUB_EN
        output in_sub,
`endif
        output out_ready,
        input  in_ready, out_valid, out_sum, out_cout
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin,
`ifdef WIDE_ADD_SUB_EN
        input  in_sub,
`endif
        input  out_ready,
        output in_ready, out_valid, out_sum, out_cout
    );

endinterface
`default_nettype wire

// File: rtl/wide_add_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : wide_add_sequencer
// Brief   : Multi-precision adder sequencing one 16-bit slice per cycle through
//           an external combinational adder. Define WIDE_ADD_SUB_EN for A-B.
// Revision: 1.0 - initial release
// ============================================================================
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  wire                clk,
    input  wire                rst,
    wide_add_sequencer_if.slave bus,
    output logic [SLICE_W-1:0] add_x,
    output logic [SLICE_W-1:0] add_y,
    output logic               add_cin,
    input  wire  [SLICE_W-1:0] add_sum,
    input  wire                add_cout
);

    localparam int                c_W     = SLICE_W * WORDS;
    localparam int                c_IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(WORDS - 1);

    state_t             r_state;
    logic [c_W-1:0]     r_a;
    logic [c_W-1:0]     r_b;
    logic [c_W-1:0]     r_sum;
    logic               r_carry;
    logic               r_cout;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_in_ready;
    logic               r_out_valid;

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_sum;
    assign bus.out_cout  = r_cout;

    // Adder operands are forced to zero whenever no slice is in flight.
    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_cin = 1'b0;
        if (r_state == RUN) begin
            add_x   = r_a[SLICE_W*r_idx +: SLICE_W];
            add_y   = r_b[SLICE_W*r_idx +: SLICE_W];
            add_cin = r_carry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a <= bus.in_a;
`ifdef WIDE_ADD_SUB_EN
                        // Two's-complement subtract: invert B and force carry-in.
                        if (bus.in_sub) begin
                            r_b     <= ~bus.in_b;
                            r_carry <= 1'b1;
                        end else begin
                            r_b     <= bus.in_b;
                            r_carry <= bus.in_cin;
                        end
`else
                        r_b     <= bus.in_b;
                        r_carry <= bus.in_cin;
`endif
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_sum[SLICE_W*r_idx +: SLICE_W] <= add_sum;
                    r_carry <= add_cout;
                    if (r_idx == c_LAST) begin
                        r_cout      <= add_cout;
                        r_idx       <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx + c_IDX_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

Multi-precision add sequencer that drives the team's 16-bit combinational adder one slice per cycle. It accepts WORDS×16-bit operands over a valid/ready handshake and presents each 16-bit slice and the running carry to the adder. It captures each slice sum and returns the full-width sum and carry-out over a second valid/ready handshake. It sits directly upstream and downstream of the 16-bit adder: it feeds the adder's operands and consumes the adder's sum and carry-out.

## Interface
- WORDS, 4, number of 16-bit slices; legal range 1..16; operand width is 16*WORDS.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand request.
- in_ready  out  1  high only in IDLE.
- in_a  in  16*WORDS  operand A.
- in_b  in  16*WORDS  operand B.
- in_cin  in  1  carry into slice 0.
- in_sub  in  1  subtract request; present only with WIDE_ADD_SUB_EN.
- out_valid  out  1  result available.
- out_ready  in  1  result accepted.
- out_sum  out  16*WORDS  result, registered.
- out_cout  out  1  carry out of the top slice, registered.
- add_x  out  16  adder operand X.
- add_y  out  16  adder operand Y.
- add_cin  out  1  adder carry-in.
- add_sum  in  16  adder sum; a combinational function of add_x, add_y and add_cin within the same cycle.
- add_cout  in  1  adder carry-out; same-cycle combinational.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE
  - in_ready=1.
  - On in_valid: register a_reg=in_a and b_reg=in_b, set carry_reg=in_cin, set idx=0, go to RUN.
- RUN
  - add_x=a_reg[16*idx +: 16], add_y=b_reg[16*idx +: 16], add_cin=carry_reg.
  - Each edge: out_sum[16*idx +: 16]<=add_sum, carry_reg<=add_cout, idx<=idx+1.
  - When idx==WORDS-1: out_cout<=add_cout and go to DONE.
- DONE
  - out_valid=1.
  - out_sum and out_cout are held stable.
  - On out_ready: go to IDLE.
- add_x, add_y and add_cin are 0 outside RUN.
- in_a, in_b and in_cin are ignored outside IDLE.
- out_sum slices not yet written in the current operation keep their previous values. They are observable only after DONE.
- idx width is max(1, clog2(WORDS)).
- WORDS=1: RUN lasts exactly one cycle.
- Arithmetic is modulo 2^(16*WORDS), with carry-out reported in out_cout.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_cout=0, carry_reg=0, idx=0, add_x/add_y/add_cin=0.
- Reset mid-operation (RUN or DONE) aborts the operation and discards the result. The cycle after rst, the block is in IDLE with all reset values.
- Latency: with acceptance at edge N, out_valid is high from edge N+WORDS.
- Minimum issue interval: WORDS+2 cycles (WORDS RUN cycles + 1 DONE + 1 IDLE). No back-to-back acceptance from DONE.
- Backpressure: DONE holds indefinitely while out_ready=0.
- rst has priority over every handshake in the same cycle.

## Configuration
- WIDE_ADD_SUB_EN defined:
  - in_sub port exists.
  - On acceptance with in_sub=1: b_reg captures ~in_b and carry_reg captures 1, computing A−B (in_cin ignored).
  - out_cout=1 means no borrow.
  - in_sub=0 behaves exactly as add.
- Undefined: in_sub port absent; add only.

## Structure
- Shared package wide_add_pkg holds:
  - SLICE_W=16.
  - the state enum typedef (IDLE, RUN, DONE).
- No sub-module. The 16-bit adder stays an external neighbour, connected through the add_* ports at the next level up.

## Test plan
- WORDS=4, A=0x0000_0000_0000_FFFF, B=0x1, cin=0 -> out_sum=0x0000_0000_0001_0000, out_cout=0; out_valid exactly 4 cycles after acceptance.
- A=0xFFFF_FFFF_FFFF_FFFF, B=0x1, cin=0 -> out_sum=0, out_cout=1 (carry ripples through all four slices).
- Hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new data -> out_valid stays 1, out_sum unchanged, in_ready=0, new data never accepted.
- Assert rst for one cycle in RUN at idx=2 -> next cycle in_ready=1, out_valid=0, add_x/add_y/add_cin=0. A following 3+4 completes with out_sum=7.
- WIDE_ADD_SUB_EN defined:
  - 5−7 -> out_sum=0xFFFF_FFFF_FFFF_FFFE, out_cout=0.
  - 7−5 -> out_sum=2, out_cout=1.
- WORDS=1, A=0xFFFF, B=0x0001, cin=1 -> out_sum=0x0001, out_cout=1, latency 1 cycle.
